// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among NUM_REQ requesters.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to add TIMEOUT_CYCLES parameter and o_err port.
//
// state   | meaning
// IDLE    | no owner; pick next requester round-robin from ptr
// ISSUE   | operands registered, raise mult_start
// WAIT    | hold mult_start until multiplier ready, then latch product
// CAPTURE | done pulse to owner, advance ptr
// RELEASE | wait for multiplier ready to fall before freeing the grant
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 32
`endif
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*WIDTH-1:0]   i_op_a,
    input  logic [NUM_REQ*WIDTH-1:0]   i_op_b,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [NUM_REQ-1:0]         o_done,
    output logic [2*WIDTH-1:0]         o_product,
    output logic                       o_busy,
    output logic                       o_mult_start,
    output logic [WIDTH-1:0]           o_mult_a,
    output logic [WIDTH-1:0]           o_mult_b,
    input  logic                       i_mult_ready,
    input  logic [2*WIDTH-1:0]         i_mult_product
`ifdef MULT_ARB_TIMEOUT_EN
    ,
    output logic                       o_err
`endif
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]           r_state;
    logic [IDXW-1:0]      r_ptr;
    logic [IDXW-1:0]      r_idx;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_start;
    logic [WIDTH-1:0]     r_mult_a;
    logic [WIDTH-1:0]     r_mult_b;

    logic                 w_found;
    logic [IDXW-1:0]      w_sel;
    logic [IDXW-1:0]      w_ptr_next;
    int                   w_cand;

    // First set request at or above ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = IDXW'(w_cand);
            end
        end
    end

    assign w_ptr_next = (r_idx == IDXW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TMO_W-1:0]     r_tmo;
    logic                 r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_product <= '0;
            r_start   <= 1'b0;
            r_mult_a  <= '0;
            r_mult_b  <= '0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx    <= w_sel;
                        r_grant  <= NUM_REQ'(1) << w_sel;
                        r_mult_a <= i_op_a[w_sel*WIDTH +: WIDTH];
                        r_mult_b <= i_op_b[w_sel*WIDTH +: WIDTH];
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b1;
                    r_tmo   <= TMO_W'(TIMEOUT_CYCLES - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mult_ready) begin
                        r_product <= i_mult_product;
                        r_done    <= r_grant;
                        r_start   <= 1'b0;
                        r_state   <= S_CAPTURE;
                    end else if (r_tmo == '0) begin
                        // Abort: skip this requester so it cannot stall the others.
                        r_err   <= 1'b1;
                        r_start <= 1'b0;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_ptr   <= w_ptr_next;
                    r_tmo   <= TMO_W'(TIMEOUT_CYCLES - 1);
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!i_mult_ready) begin
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end else if (r_tmo == '0) begin
                        r_err   <= 1'b1;
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_err = r_err;
`else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_product <= '0;
            r_start   <= 1'b0;
            r_mult_a  <= '0;
            r_mult_b  <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx    <= w_sel;
                        r_grant  <= NUM_REQ'(1) << w_sel;
                        r_mult_a <= i_op_a[w_sel*WIDTH +: WIDTH];
                        r_mult_b <= i_op_b[w_sel*WIDTH +: WIDTH];
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_mult_ready) begin
                        r_product <= i_mult_product;
                        r_done    <= r_grant;
                        r_start   <= 1'b0;
                        r_state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!i_mult_ready) begin
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

    assign o_grant      = r_grant;
    assign o_done       = r_done;
    assign o_product    = r_product;
    assign o_busy       = (r_state != S_IDLE);
    assign o_mult_start = r_start;
    assign o_mult_a     = r_mult_a;
    assign o_mult_b     = r_mult_b;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one sequential multiplier among NUM_REQ requesters. It grants one requester at a time and drives the multiplier's start/ready handshake. It returns the captured product with a one-cycle done pulse to the granted requester. It sits between requester blocks and the multiplier core.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width; product is 2*WIDTH
- TIMEOUT_CYCLES, 32, watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is high
- req  in  NUM_REQ  per-requester request level; held until that requester's done pulse
- op_a  in  NUM_REQ*WIDTH  multiplicands, requester i at bits [i*WIDTH +: WIDTH]
- op_b  in  NUM_REQ*WIDTH  multipliers, same packing
- grant  out  NUM_REQ  one-hot owner of the multiplier, all zero when idle
- done  out  NUM_REQ  one-hot, one-cycle pulse when the product is valid
- product  out  2*WIDTH  captured result, held until the next capture
- busy  out  1  high in every state except IDLE
- mult_start  out  1  start level to the multiplier
- mult_a, mult_b  out  WIDTH  operands registered at grant and stable while busy
- mult_ready  in  1  multiplier ready level
- mult_product  in  2*WIDTH  multiplier result, valid while mult_ready is high
- err  out  1  sticky timeout flag; present only with MULT_ARB_TIMEOUT_EN

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, RELEASE.
- IDLE: if any req bit is high, select the first set bit searching from ptr upward with wrap. Register grant, mult_a and mult_b, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: mult_start=1, go to WAIT.
- WAIT: mult_start=1. When mult_ready=1, latch mult_product into product and go to CAPTURE.
- CAPTURE: mult_start=0. Pulse done at the granted index. Set ptr = granted index + 1, wrapping to 0 after NUM_REQ-1. Go to RELEASE.
- RELEASE: mult_start=0. When mult_ready=0, clear grant and go to IDLE. This guarantees the multiplier has returned to idle before the next start.
- req changes while the FSM is not in IDLE are ignored.
- A requester that drops req mid-operation still receives its done pulse.
- A requester that keeps req high after done is eligible again, but at lowest priority.
- Operands are sampled only at grant. Later op_a/op_b changes do not affect the running multiplication.
- Arithmetic is unsigned. Product width is exactly 2*WIDTH, with no truncation.

## Timing
- Reset values:
  - Outputs: grant=0, done=0, product=0, busy=0, mult_start=0, mult_a=0, mult_b=0, err=0.
  - Internal: state=IDLE, ptr=0.
- Reset mid-operation: mult_start drops on the reset edge and no done pulse is issued. Because the multiplier then sees start low, it returns to idle on its own.
- From req high in IDLE:
  - grant is visible 1 cycle later.
  - mult_start rises 2 cycles later.
  - done rises 1 cycle after mult_ready is first sampled high in WAIT.
- Against a multiplier whose ready follows start by 10 cycles: req→done is 13 cycles, and back-to-back grants are spaced by the RELEASE wait plus 1 cycle in IDLE.
- Simultaneous requests: exactly one grant per transaction, chosen round-robin from ptr.
- mult_ready high while in IDLE or ISSUE is ignored; the product is only captured in WAIT.

## Configuration
- MULT_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT and RELEASE and is cleared on entry to each.
  - If it reaches TIMEOUT_CYCLES, set err (sticky until reset) and drop mult_start. Go to IDLE with grant cleared and no done pulse.
  - ptr advances past the aborted requester.
- MULT_ARB_TIMEOUT_EN undefined:
  - No counter and no err port.
  - WAIT and RELEASE wait indefinitely.

## Test plan
- Single request: req=0001, op_a[0]=8'd12, op_b[0]=8'd13 → grant=0001 next cycle. After mult_ready, done=0001 for one cycle and product=16'd156.
- Simultaneous: req=1111 held, ptr=0 → grants issue in order 0,1,2,3,0. Each done is one-hot, and no done overlaps a different grant.
- Boundary operands: 8'hFF × 8'hFF → product=16'hFE01. 8'h00 × 8'h5A → product=16'h0000.
- Operand change after grant: op_a changes from 8'd3 to 8'd7 during WAIT, op_b=8'd5 → product=16'd15.
- Reset asserted in WAIT → the next cycle shows mult_start=0, grant=0, busy=0, no done pulse. A new req=0100 is then granted with ptr=0 search, giving grant=0100.
- With MULT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=32, mult_ready tied low → err=1 after 32 cycles in WAIT, grant=0, done never asserts. The next requester is granted normally.
